// File: rtl/lut_bank_pkg.sv
// Shared types and sizing helpers for the lut_bank programmable truth-table bank.
package lut_bank_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} cfg_state_t;

    // Ceiling log2 with a minimum of 1, so select/index ports never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned beats(input int unsigned n_in, input int unsigned cfg_w);
        return (32'd1 << n_in) / cfg_w;
    endfunction

endpackage

// File: rtl/lut_bank_cfg_fsm.sv
// Config loader control: valid/ready handshake, beat counter, target latch, abort and commit strobe.
module lut_bank_cfg_fsm
    import lut_bank_pkg::*;
#(
    parameter int unsigned BEATS = 4,
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic             cfg_abort,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             beat_we,
    output logic [CNT_W-1:0] beat_idx,
    output logic [SEL_W-1:0] sel
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    cfg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             accept;

    // A beat offered together with abort is refused.
    assign cfg_ready = (state_q != COMMIT) && !cfg_abort;
    assign accept    = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_abort) begin
                    cnt_d = '0;
                end else if (accept) begin
                    sel_d = cfg_sel;
                    if (BEATS == 1) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LOAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                if (cfg_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (cnt_q == LAST) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign cfg_done = (state_q == COMMIT);
    assign beat_we  = accept;
    assign beat_idx = cnt_q;
    assign sel      = sel_q;

endmodule

// File: rtl/lut_bank.sv
// Bank of N_OUT runtime-loadable N_IN-input LUTs with shadow+commit reload and registered outputs.
// Optional committed-table readback port enabled by defining LUT_READBACK_EN.
module lut_bank
    import lut_bank_pkg::*;
#(
    parameter int unsigned N_IN  = 5,
    parameter int unsigned N_OUT = 8,
    parameter int unsigned CFG_W = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    input  logic [N_IN-1:0]                        in_vec,
    output logic                                   out_valid,
    output logic [N_OUT-1:0]                       out_vec,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [clog2(N_OUT)-1:0]                cfg_sel,
    input  logic [CFG_W-1:0]                       cfg_data,
    input  logic                                   cfg_abort,
    output logic                                   cfg_done,
    input  logic [clog2(N_OUT)-1:0]                rd_sel,
    input  logic [clog2(beats(N_IN, CFG_W))-1:0]   rd_idx,
    output logic [CFG_W-1:0]                       rd_data
);

    localparam int unsigned DEPTH = 32'd1 << N_IN;
    localparam int unsigned BEATS = beats(N_IN, CFG_W);
    localparam int unsigned SEL_W = clog2(N_OUT);
    localparam int unsigned CNT_W = clog2(BEATS);

    logic [DEPTH-1:0] lut_q [N_OUT];
    logic [DEPTH-1:0] shadow_q;
    logic [N_OUT-1:0] eval_d, out_vec_q;
    logic             out_valid_q;
    logic             beat_we;
    logic [CNT_W-1:0] beat_idx;
    logic [SEL_W-1:0] sel;

    lut_bank_cfg_fsm #(
        .BEATS (BEATS),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) u_cfg_fsm (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_abort (cfg_abort),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .beat_we   (beat_we),
        .beat_idx  (beat_idx),
        .sel       (sel)
    );

    always_comb begin
        eval_d = '0;
        for (int j = 0; j < int'(N_OUT); j++) begin
            eval_d[j] = lut_q[j][in_vec];
        end
    end

    // Eval and commit share an edge, so an eval in the commit cycle still sees the old table.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q    <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            for (int j = 0; j < int'(N_OUT); j++) begin
                lut_q[j] <= '0;
            end
        end else begin
            if (beat_we) begin
                shadow_q[beat_idx*CFG_W +: CFG_W] <= cfg_data;
            end
            if (cfg_done) begin
                for (int j = 0; j < int'(N_OUT); j++) begin
                    if (sel == SEL_W'(j)) lut_q[j] <= shadow_q;
                end
            end
            out_valid_q <= in_valid;
            if (in_valid) out_vec_q <= eval_d;
        end
    end

    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;

`ifdef LUT_READBACK_EN
    logic [CFG_W-1:0] rd_d, rd_q;

    // Select by comparison so a non-power-of-two bank returns 0 for unused codes.
    always_comb begin
        rd_d = '0;
        for (int j = 0; j < int'(N_OUT); j++) begin
            if (rd_sel == SEL_W'(j)) rd_d = lut_q[j][rd_idx*CFG_W +: CFG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    assign rd_data = rd_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_sel, rd_idx};
    assign rd_data   = '0;
`endif

endmodule

// File: tb/tb_lut_bank.sv
// Directed self-checking bench for lut_bank: reset, loads, back-pressure, abort, commit race.
module tb_lut_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] in_vec;
    logic       out_valid;
    logic [7:0] out_vec;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_sel;
    logic [7:0] cfg_data;
    logic       cfg_abort;
    logic       cfg_done;
    logic [2:0] rd_sel;
    logic [1:0] rd_idx;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;

    lut_bank dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_vec   (out_vec),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .cfg_abort (cfg_abort),
        .cfg_done  (cfg_done),
        .rd_sel    (rd_sel),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] rd_exp;
        logic       done_seen;

        reset = 1'b1; in_valid = 1'b1; in_vec = 5'h1F;
        cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0; cfg_abort = 1'b0;
        rd_sel = '0; rd_idx = '0;
        tick(); tick();
        check("rst_out_vec", 32'(out_vec), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_done", 32'(cfg_done), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        reset = 1'b0; in_valid = 1'b0;
        tick();
        check("rel_ready", 32'(cfg_ready), 32'h1);
        check("rel_out_valid", 32'(out_valid), 32'h0);

        // Majority of A,B,C into table 0
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_data = 8'hE8;
        tick(); tick(); tick();
        check("maj_no_early_done", 32'(cfg_done), 32'h0);
        tick();
        check("maj_done", 32'(cfg_done), 32'h1);
        check("maj_commit_not_ready", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b0;
        tick();
        check("maj_done_pulse", 32'(cfg_done), 32'h0);
        in_valid = 1'b1; in_vec = 5'b00011;
        tick();
        check("maj_valid", 32'(out_valid), 32'h1);
        check("maj_00011", 32'(out_vec), 32'h01);
        in_vec = 5'b00001;
        tick();
        check("maj_00001", 32'(out_vec), 32'h00);
        in_vec = 5'b10011;
        tick();
        check("maj_10011", 32'(out_vec), 32'h01);
        in_valid = 1'b0; rd_sel = 3'd0; rd_idx = 2'd2;
        tick();
        check("hold_valid", 32'(out_valid), 32'h0);
        check("hold_vec", 32'(out_vec), 32'h01);
`ifdef LUT_READBACK_EN
        rd_exp = 8'hE8;
`else
        rd_exp = 8'h00;
`endif
        check("rd_t0_b2", 32'(rd_data), 32'(rd_exp));

        // Table 3 all ones; a beat held through COMMIT must wait for IDLE
        cfg_valid = 1'b1; cfg_sel = 3'd3; cfg_data = 8'hFF;
        tick(); tick(); tick(); tick();
        check("bp_commit_done", 32'(cfg_done), 32'h1);
        check("bp_commit_ready", 32'(cfg_ready), 32'h0);
        cfg_sel = 3'd2; cfg_data = 8'hA5;
        tick();
        check("bp_idle_ready", 32'(cfg_ready), 32'h1);
        check("bp_idle_done", 32'(cfg_done), 32'h0);
        tick(); tick(); tick();
        check("bp_t2_no_early_done", 32'(cfg_done), 32'h0);
        tick();
        check("bp_t2_done", 32'(cfg_done), 32'h1);
        cfg_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_vec = 5'(i);
            tick();
            check($sformatf("t3_ones_%0d", i), 32'(out_vec[3]), 32'h1);
        end
        in_vec = 5'h00; tick();
        check("mix_00", 32'(out_vec), 32'h0C);
        in_vec = 5'h1F; tick();
        check("mix_1f", 32'(out_vec), 32'h0D);
        in_vec = 5'h06; tick();
        check("mix_06", 32'(out_vec), 32'h09);
        in_valid = 1'b0;

        // Abort after two beats into table 1
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_data = 8'h55;
        tick(); tick();
        cfg_abort = 1'b1;
        #1;
        check("abort_not_ready", 32'(cfg_ready), 32'h0);
        tick();
        cfg_abort = 1'b0; cfg_valid = 1'b0;
        done_seen = cfg_done;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_vec = 5'(i);
            tick();
            done_seen = done_seen | cfg_done;
            check($sformatf("abort_t1_%0d", i), 32'(out_vec[1]), 32'h0);
        end
        check("abort_no_done", 32'(done_seen), 32'h0);
        in_valid = 1'b0;

        // Full load of table 1 after abort; abort during COMMIT is ignored
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_data = 8'h0F;
        tick(); tick(); tick();
        check("race_no_early_done", 32'(cfg_done), 32'h0);
        tick();
        check("race_done", 32'(cfg_done), 32'h1);
        cfg_valid = 1'b0; cfg_abort = 1'b1; in_valid = 1'b1; in_vec = 5'h00;
        tick();
        check("race_old_table", 32'(out_vec), 32'h0C);
        cfg_abort = 1'b0;
        tick();
        check("race_new_table", 32'(out_vec), 32'h0E);
        in_valid = 1'b0; rd_sel = 3'd1; rd_idx = 2'd3;
        tick();
`ifdef LUT_READBACK_EN
        rd_exp = 8'h0F;
`else
        rd_exp = 8'h00;
`endif
        check("rd_t1_b3", 32'(rd_data), 32'(rd_exp));

        // Reset in the middle of a load
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_data = 8'h00;
        tick(); tick();
        cfg_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", 32'(cfg_ready), 32'h1);
        check("mid_rst_vec", 32'(out_vec), 32'h00);
        check("mid_rst_rd", 32'(rd_data), 32'h00);
        in_valid = 1'b1; in_vec = 5'h1F;
        tick();
        check("mid_rst_tables", 32'(out_vec), 32'h00);
        check("mid_rst_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        cfg_valid = 1'b1; cfg_sel = 3'd2; cfg_data = 8'h81;
        tick(); tick(); tick();
        check("post_rst_no_early_done", 32'(cfg_done), 32'h0);
        tick();
        check("post_rst_done", 32'(cfg_done), 32'h1);
        cfg_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_vec = 5'h00; tick();
        check("post_rst_00", 32'(out_vec), 32'h04);
        in_vec = 5'h07; tick();
        check("post_rst_07", 32'(out_vec), 32'h04);
        in_vec = 5'h01; tick();
        check("post_rst_01", 32'(out_vec), 32'h00);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
